// File: rtl/can_fd_pkg.sv
// rtl/can_fd_pkg.sv - shared CAN/CAN-FD receive types and CRC length constants
package can_fd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2
    } rx_state_e;

    localparam logic [4:0] CRC_LEN_CLASSIC = 5'd15;
    localparam logic [4:0] CRC_LEN_FD_SHORT = 5'd17;
    localparam logic [4:0] CRC_LEN_FD_LONG = 5'd21;

    // FD frames switch to the longer CRC once the payload exceeds 16 bytes
    function automatic logic [4:0] crc_len_for(input logic fd, input logic [6:0] len);
        if (!fd) begin
            return CRC_LEN_CLASSIC;
        end else if (len <= 7'd16) begin
            return CRC_LEN_FD_SHORT;
        end else begin
            return CRC_LEN_FD_LONG;
        end
    endfunction

endpackage

// File: rtl/can_dlc_decoder.sv
// rtl/can_dlc_decoder.sv - DLC to payload byte count for classic and FD frames
module can_dlc_decoder (
    input  logic [3:0] dlc_i,
    input  logic       fd_i,
    output logic [6:0] len_o
);

    // classic frames saturate at 8 bytes; FD frames use the extended table above 8
    always_comb begin
        len_o = 7'd8;
        if (dlc_i <= 4'd8) begin
            len_o = {3'd0, dlc_i};
        end else if (fd_i) begin
            case (dlc_i)
                4'd9:    len_o = 7'd12;
                4'd10:   len_o = 7'd16;
                4'd11:   len_o = 7'd20;
                4'd12:   len_o = 7'd24;
                4'd13:   len_o = 7'd32;
                4'd14:   len_o = 7'd48;
                default: len_o = 7'd64;
            endcase
        end
    end

endmodule

// File: rtl/can_rx_data_ctrl.sv
// rtl/can_rx_data_ctrl.sv - assembles de-stuffed data-field bits into addressed bytes
module can_rx_data_ctrl
    import can_fd_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       dlc_valid_in,
    input  logic [3:0] dlc_in,
    input  logic       fd_frame_in,
    input  logic       bit_valid_in,
    input  logic       bit_in,
    input  logic       frame_abort_in,
    output logic [7:0] byte_out,
    output logic [5:0] byte_addr_out,
    output logic       byte_wr_out,
    output logic       data_done_out,
    output logic [4:0] crc_len_out,
    output logic       busy_out,
    output logic [6:0] len_out
);

    rx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] byte_q, byte_d;
    logic [5:0] addr_q, addr_d;
    logic       wr_q, wr_d;
    logic       done_q, done_d;
    logic [4:0] crc_len_q, crc_len_d;
    logic [6:0] len_q, len_d;
    logic [6:0] dec_len;

    can_dlc_decoder u_dlc_decoder (
        .dlc_i (dlc_in),
        .fd_i  (fd_frame_in),
        .len_o (dec_len)
    );

    // all block state, cleared asynchronously so a mid-frame reset leaves nothing behind
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 7'd0;
            byte_q     <= 8'd0;
            addr_q     <= 6'd0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            crc_len_q  <= 5'd0;
            len_q      <= 7'd0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            byte_q     <= byte_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            crc_len_q  <= crc_len_d;
            len_q      <= len_d;
        end
    end

    // next-state: abort wins over everything, then DLC latch in IDLE, bit assembly in DATA
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        crc_len_d  = crc_len_q;
        len_d      = len_q;

        if (frame_abort_in) begin
            state_d    = ST_IDLE;
            shift_d    = 8'd0;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 7'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // a bit strobe coinciding with the DLC strobe is dropped here
                    if (dlc_valid_in) begin
                        len_d      = dec_len;
                        crc_len_d  = crc_len_for(fd_frame_in, dec_len);
                        shift_d    = 8'd0;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 7'd0;
                        if (dec_len == 7'd0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_valid_in) begin
                        shift_d   = {shift_q[6:0], bit_in};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_d     = {shift_q[6:0], bit_in};
                            addr_d     = byte_cnt_q[5:0];
                            wr_d       = 1'b1;
                            byte_cnt_d = byte_cnt_q + 7'd1;
                            // last byte: leave DATA so the counter can never pass len
                            if (byte_cnt_q == len_q - 7'd1) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign byte_out      = byte_q;
    assign byte_addr_out = addr_q;
    assign byte_wr_out   = wr_q & ~frame_abort_in;
    assign data_done_out = done_q & ~frame_abort_in;
    assign crc_len_out   = crc_len_q;
    assign len_out       = len_q;
    assign busy_out      = (state_q == ST_DATA);

endmodule

// File: tb/tb_can_rx_data_ctrl.sv
// tb/tb_can_rx_data_ctrl.sv - randomized self-checking bench for can_rx_data_ctrl
module tb_can_rx_data_ctrl;

    logic       clk_in;
    logic       rst_n_in;
    logic       dlc_valid_in;
    logic [3:0] dlc_in;
    logic       fd_frame_in;
    logic       bit_valid_in;
    logic       bit_in;
    logic       frame_abort_in;
    logic [7:0] byte_out;
    logic [5:0] byte_addr_out;
    logic       byte_wr_out;
    logic       data_done_out;
    logic [4:0] crc_len_out;
    logic       busy_out;
    logic [6:0] len_out;

    int n_cmp;
    int n_err;
    int cyc;
    int done_cnt;
    int done_cyc;

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
        logic       dn;
    } wr_t;
    wr_t wr_q[$];

    can_rx_data_ctrl dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .dlc_valid_in   (dlc_valid_in),
        .dlc_in         (dlc_in),
        .fd_frame_in    (fd_frame_in),
        .bit_valid_in   (bit_valid_in),
        .bit_in         (bit_in),
        .frame_abort_in (frame_abort_in),
        .byte_out       (byte_out),
        .byte_addr_out  (byte_addr_out),
        .byte_wr_out    (byte_wr_out),
        .data_done_out  (data_done_out),
        .crc_len_out    (crc_len_out),
        .busy_out       (busy_out),
        .len_out        (len_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (byte_wr_out) wr_q.push_back('{byte_addr_out, byte_out, data_done_out});
        if (data_done_out) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    function automatic int model_len(input bit fd, input int dlc);
        int fd_tab[7] = '{12, 16, 20, 24, 32, 48, 64};
        if (dlc <= 8) return dlc;
        if (!fd) return 8;
        return fd_tab[dlc - 9];
    endfunction

    function automatic int model_crc(input bit fd, input int len);
        if (!fd) return 15;
        return (len <= 16) ? 17 : 21;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) step();
        bit_valid_in = 1'b1;
        bit_in = b;
        step();
        bit_valid_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int k = 7; k >= 0; k--) send_bit(v[k], gaps);
    endtask

    task automatic pulse_dlc(input bit fd, input logic [3:0] dlc);
        fd_frame_in = fd;
        dlc_in = dlc;
        dlc_valid_in = 1'b1;
        step();
        dlc_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (byte_out !== 8'd0) begin n_err++; $display("FAIL reset_byte: got %0h expected 0", byte_out); end
        n_cmp++; if (byte_addr_out !== 6'd0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", byte_addr_out); end
        n_cmp++; if (byte_wr_out !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b expected 0", byte_wr_out); end
        n_cmp++; if (data_done_out !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", data_done_out); end
        n_cmp++; if (crc_len_out !== 5'd0) begin n_err++; $display("FAIL reset_crc: got %0d expected 0", crc_len_out); end
        n_cmp++; if (len_out !== 7'd0) begin n_err++; $display("FAIL reset_len: got %0d expected 0", len_out); end
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    endtask

    // one complete frame: stray idle bit, DLC with a coincident bit, payload, then full check
    task automatic test_frame(input string name, input bit fd, input logic [3:0] dlc,
                              input bit incr, input bit gaps);
        int exp_len;
        int exp_crc;
        int c_dlc;
        int w0;
        int d0;
        logic [7:0] bytes[64];
        exp_len = model_len(fd, int'(dlc));
        exp_crc = model_crc(fd, exp_len);
        for (int i = 0; i < 64; i++) bytes[i] = incr ? 8'(i) : 8'($urandom);
        w0 = wr_q.size();
        d0 = done_cnt;
        bit_valid_in = 1'b1;
        bit_in = 1'($urandom);
        step();
        bit_valid_in = 1'($urandom_range(0, 1));
        pulse_dlc(fd, dlc);
        bit_valid_in = 1'b0;
        c_dlc = cyc;
        n_cmp++; if (len_out !== 7'(exp_len)) begin n_err++; $display("FAIL %s_len: got %0d expected %0d", name, len_out, exp_len); end
        n_cmp++; if (crc_len_out !== 5'(exp_crc)) begin n_err++; $display("FAIL %s_crc: got %0d expected %0d", name, crc_len_out, exp_crc); end
        n_cmp++; if (busy_out !== (exp_len != 0)) begin n_err++; $display("FAIL %s_busy: got %b expected %b", name, busy_out, exp_len != 0); end
        for (int i = 0; i < exp_len; i++) send_byte(bytes[i], gaps);
        repeat (3) step();
        n_cmp++; if (wr_q.size() - w0 != exp_len) begin n_err++; $display("FAIL %s_nwr: got %0d expected %0d", name, wr_q.size() - w0, exp_len); end
        for (int i = 0; i < exp_len && w0 + i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[w0+i].a !== 6'(i) || wr_q[w0+i].d !== bytes[i] || wr_q[w0+i].dn !== (i == exp_len - 1)) begin
                n_err++;
                $display("FAIL %s_wr%0d: got addr %0d data %0h done %b expected addr %0d data %0h done %b",
                         name, i, wr_q[w0+i].a, wr_q[w0+i].d, wr_q[w0+i].dn, i, bytes[i], i == exp_len - 1);
            end
        end
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL %s_ndone: got %0d expected 1", name, done_cnt - d0); end
        if (exp_len == 0) begin
            n_cmp++; if (done_cyc != c_dlc) begin n_err++; $display("FAIL %s_done_lat: got cycle %0d expected %0d", name, done_cyc, c_dlc); end
        end
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL %s_idle: got busy %b expected 0", name, busy_out); end
    endtask

    task automatic test_zero_len();
        test_frame("zero_classic", 1'b0, 4'h0, 1'b0, 1'b0);
        test_frame("zero_fd", 1'b1, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        int w0;
        int d0;
        w0 = wr_q.size();
        d0 = done_cnt;
        pulse_dlc(1'b1, 4'h9);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
        for (int k = 0; k < 5; k++) send_bit(1'($urandom), 1'b0);
        frame_abort_in = 1'b1;
        step();
        frame_abort_in = 1'b0;
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy_out); end
        for (int k = 0; k < 6; k++) send_bit(1'($urandom), 1'b0);
        repeat (3) step();
        n_cmp++; if (wr_q.size() - w0 != 3) begin n_err++; $display("FAIL abort_nwr: got %0d expected 3", wr_q.size() - w0); end
        n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL abort_done: got %0d expected 0", done_cnt - d0); end
        test_frame("abort_restart", 1'b0, 4'h8, 1'b0, 1'b1);
    endtask

    task automatic test_dlc_in_data();
        int w0;
        logic [7:0] bytes[8];
        for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
        w0 = wr_q.size();
        pulse_dlc(1'b0, 4'h8);
        for (int i = 0; i < 2; i++) send_byte(bytes[i], 1'b0);
        pulse_dlc(1'b1, 4'hF);
        n_cmp++; if (len_out !== 7'd8) begin n_err++; $display("FAIL dlc_in_data_len: got %0d expected 8", len_out); end
        n_cmp++; if (crc_len_out !== 5'd15) begin n_err++; $display("FAIL dlc_in_data_crc: got %0d expected 15", crc_len_out); end
        for (int i = 2; i < 8; i++) send_byte(bytes[i], 1'b1);
        repeat (3) step();
        n_cmp++; if (wr_q.size() - w0 != 8) begin n_err++; $display("FAIL dlc_in_data_nwr: got %0d expected 8", wr_q.size() - w0); end
        for (int i = 0; i < 8 && w0 + i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[w0+i].a !== 6'(i) || wr_q[w0+i].d !== bytes[i]) begin
                n_err++;
                $display("FAIL dlc_in_data_wr%0d: got addr %0d data %0h expected addr %0d data %0h",
                         i, wr_q[w0+i].a, wr_q[w0+i].d, i, bytes[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_frame("b2b_a", 1'b1, 4'h2, 1'b0, 1'b0);
        test_frame("b2b_b", 1'b0, 4'h3, 1'b0, 1'b0);
        test_frame("b2b_c", 1'b1, 4'hA, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            test_frame($sformatf("rand%0d", n), 1'($urandom), 4'($urandom), 1'b0, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        int d0;
        pulse_dlc(1'b1, 4'hA);
        send_byte(8'hA5, 1'b0);
        for (int k = 0; k < 3; k++) send_bit(1'($urandom), 1'b0);
        #2;
        rst_n_in = 1'b0;
        #1;
        w0 = wr_q.size();
        d0 = done_cnt;
        n_cmp++; if (byte_out !== 8'd0) begin n_err++; $display("FAIL rstmid_byte: got %0h expected 0", byte_out); end
        n_cmp++; if (byte_addr_out !== 6'd0) begin n_err++; $display("FAIL rstmid_addr: got %0d expected 0", byte_addr_out); end
        n_cmp++; if (crc_len_out !== 5'd0) begin n_err++; $display("FAIL rstmid_crc: got %0d expected 0", crc_len_out); end
        n_cmp++; if (len_out !== 7'd0) begin n_err++; $display("FAIL rstmid_len: got %0d expected 0", len_out); end
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy_out); end
        n_cmp++; if (byte_wr_out !== 1'b0 || data_done_out !== 1'b0) begin n_err++; $display("FAIL rstmid_strobes: got wr %b done %b expected 0 0", byte_wr_out, data_done_out); end
        step();
        rst_n_in = 1'b1;
        for (int k = 0; k < 8; k++) send_bit(1'($urandom), 1'b0);
        repeat (3) step();
        n_cmp++; if (wr_q.size() != w0 || done_cnt != d0) begin n_err++; $display("FAIL rstmid_after: got %0d writes %0d dones expected 0 0", wr_q.size() - w0, done_cnt - d0); end
        test_frame("rstmid_restart", 1'b1, 4'h1, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        done_cnt = 0;
        done_cyc = 0;
        rst_n_in = 1'b0;
        dlc_valid_in = 1'b0;
        dlc_in = 4'h0;
        fd_frame_in = 1'b0;
        bit_valid_in = 1'b0;
        bit_in = 1'b0;
        frame_abort_in = 1'b0;
        repeat (2) step();
        test_reset();
        rst_n_in = 1'b1;
        step();
        test_frame("classic_f", 1'b0, 4'hF, 1'b0, 1'b1);
        test_frame("fd_9", 1'b1, 4'h9, 1'b1, 1'b0);
        test_frame("fd_b", 1'b1, 4'hB, 1'b0, 1'b1);
        test_frame("fd_f", 1'b1, 4'hF, 1'b0, 1'b0);
        test_zero_len();
        test_abort();
        test_dlc_in_data();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
